dg_pkt_gen: RTL and testbench

// Command consumer and packet generator at the data_gen end of the fetch interface. Accepts one
// {da,prior,len} command per o_ready/i_vld handshake from the command-fetch FSM. Emits a framed

---
 rtl/dg_pkg.sv | 29 ++
 rtl/dg_pkt_gen_if.sv | 35 +++
 rtl/dg_hdr_fmt.sv | 29 ++
 rtl/dg_pkt_gen.sv | 135 +++++++++++++
 tb/tb_dg_pkt_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dg_pkg.sv
// rtl/dg_pkg.sv - shared state encodings and stream word field offsets for the data_gen path.
package dg_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_GAP  = 2'd3
  } dg_state_t;

  localparam int WORD_W  = 32;
  localparam int SEQ_W   = 8;
  localparam int DA_W    = 4;
  localparam int PRIOR_W = 3;
  localparam int IDX_W   = 10;

  // Header: {seq, 7'b0, len, prior, da}
  localparam int HDR_DA_LSB    = 0;
  localparam int HDR_PRIOR_LSB = 4;
  localparam int HDR_LEN_LSB   = 7;
  localparam int HDR_SEQ_LSB   = 24;

  // Payload: {seq, da, prior, 7'b0, idx}
  localparam int PAY_IDX_LSB   = 0;
  localparam int PAY_PRIOR_LSB = 17;
  localparam int PAY_DA_LSB    = 20;
  localparam int PAY_SEQ_LSB   = 24;

endpackage

// File: rtl/dg_pkt_gen_if.sv
// rtl/dg_pkt_gen_if.sv - command and framed word stream bundle of the packet generator.
interface dg_pkt_gen_if
  import dg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10,
  parameter int CNT_W  = 16
) ();

  logic [DA_W-1:0]    da;
  logic [PRIOR_W-1:0] prior;
  logic [LEN_W-1:0]   len;
  logic               vld;
  logic               ready;

  logic               wr_vld;
  logic               wr_sop;
  logic               wr_eop;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_ready;

  logic [CNT_W-1:0]   pkt_cnt;
  logic               err;

  modport master (
    input  da, prior, len, vld, wr_ready,
    output ready, wr_vld, wr_sop, wr_eop, wr_data, pkt_cnt, err
  );

  modport slave (
    output da, prior, len, vld, wr_ready,
    input  ready, wr_vld, wr_sop, wr_eop, wr_data, pkt_cnt, err
  );

endinterface

// File: rtl/dg_hdr_fmt.sv
// rtl/dg_hdr_fmt.sv - combinational formatter for header and payload stream words.
module dg_hdr_fmt
  import dg_pkg::*;
(
  input  logic [SEQ_W-1:0]   seq,
  input  logic [DA_W-1:0]    da,
  input  logic [PRIOR_W-1:0] prior,
  input  logic [IDX_W-1:0]   len,
  input  logic [IDX_W-1:0]   idx,
  input  logic               is_hdr,
  output logic [WORD_W-1:0]  data
);

  always_comb begin
    data = '0;
    if (is_hdr) begin
      data[HDR_DA_LSB    +: DA_W]    = da;
      data[HDR_PRIOR_LSB +: PRIOR_W] = prior;
      data[HDR_LEN_LSB   +: IDX_W]   = len;
      data[HDR_SEQ_LSB   +: SEQ_W]   = seq;
    end else begin
      data[PAY_IDX_LSB   +: IDX_W]   = idx;
      data[PAY_PRIOR_LSB +: PRIOR_W] = prior;
      data[PAY_DA_LSB    +: DA_W]    = da;
      data[PAY_SEQ_LSB   +: SEQ_W]   = seq;
    end
  end

endmodule

// File: rtl/dg_pkt_gen.sv
// rtl/dg_pkt_gen.sv - command consumer emitting one header word plus len payload words per command.
module dg_pkt_gen
  import dg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10,
  parameter int IPG    = 2,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  dg_pkt_gen_if.master bus
);

  localparam int GAP_W = (IPG > 1) ? $clog2(IPG) : 1;

  dg_state_t state, state_nxt;

  logic [DA_W-1:0]    cmd_da;
  logic [PRIOR_W-1:0] cmd_prior;
  logic [LEN_W-1:0]   cmd_len;
  logic [SEQ_W-1:0]   seq;
  logic [LEN_W-1:0]   idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   pkt_cnt;
  logic               err;

  logic               ready;
  logic               wr_vld;
  logic               wr_sop;
  logic               wr_eop;
  logic               capture;
  logic               accept;
  logic               last_word;
  logic               gap_done;
  logic [DATA_W-1:0]  fmt_data;

  assign capture   = bus.vld && ready;
  assign accept    = wr_vld && bus.wr_ready;
  assign last_word = ((state == S_HDR) && (cmd_len == '0)) ||
                     ((state == S_PAY) && (idx == cmd_len - LEN_W'(1)));
  assign gap_done  = (gap_cnt == GAP_W'((IPG > 0) ? IPG - 1 : 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (capture) state_nxt = S_HDR;
      S_HDR, S_PAY: begin
        if (accept) begin
          if (last_word) state_nxt = (IPG > 0) ? S_GAP : S_IDLE;
          else           state_nxt = S_PAY;
        end
      end
      S_GAP:  if (gap_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    wr_vld = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_HDR: begin
        wr_vld = 1'b1;
        wr_sop = 1'b1;
        wr_eop = last_word;
      end
      S_PAY: begin
        wr_vld = 1'b1;
        wr_eop = last_word;
      end
      default: ;
    endcase
  end

  // seq is sampled from the sent count, so it reflects every eop accepted before this capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_da    <= '0;
      cmd_prior <= '0;
      cmd_len   <= '0;
      seq       <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      pkt_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if (capture) begin
        cmd_da    <= bus.da;
        cmd_prior <= bus.prior;
        cmd_len   <= bus.len;
        seq       <= pkt_cnt[SEQ_W-1:0];
        idx       <= '0;
      end else if (accept && (state == S_PAY)) begin
        idx <= idx + LEN_W'(1);
      end

      if (accept && last_word) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      if (bus.vld && !ready) err <= 1'b1;
    end
  end

  dg_hdr_fmt u_fmt (
    .seq    (seq),
    .da     (cmd_da),
    .prior  (cmd_prior),
    .len    (cmd_len),
    .idx    (idx),
    .is_hdr (state == S_HDR),
    .data   (fmt_data)
  );

  assign bus.ready   = ready;
  assign bus.wr_vld  = wr_vld;
  assign bus.wr_sop  = wr_sop;
  assign bus.wr_eop  = wr_eop;
  assign bus.wr_data = wr_vld ? fmt_data : '0;
  assign bus.pkt_cnt = pkt_cnt;
  assign bus.err     = err;

endmodule

// File: tb/tb_dg_pkt_gen.sv
// tb/tb_dg_pkt_gen.sv - scoreboard bench for dg_pkt_gen with randomized commands and backpressure.
module tb_dg_pkt_gen;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  int bp_mode = 0;
  int pk = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  exp_t q[$];
  exp_t held;
  bit   stall = 1'b0;

  dg_pkt_gen_if bus ();

  dg_pkt_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference words built straight from the field layout with arithmetic
  function automatic logic [31:0] hdr_word(int seq, int da, int prior, int len);
    return 32'((seq % 256) * (1 << 24) + len * (1 << 7) + prior * (1 << 4) + da);
  endfunction

  function automatic logic [31:0] pay_word(int seq, int da, int prior, int k);
    return 32'((seq % 256) * (1 << 24) + da * (1 << 20) + prior * (1 << 17) + k);
  endfunction

  task automatic issue(input int da, input int prior, input int len);
    int n;
    int seq;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    while (!bus.ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(bus.ready), 32'd1);
    bus.da    = 4'(da);
    bus.prior = 3'(prior);
    bus.len   = 10'(len);
    bus.vld   = 1'b1;
    seq = model_cnt % 256;
    e.data = hdr_word(seq, da, prior, len);
    e.sop  = 1'b1;
    e.eop  = (len == 0);
    q.push_back(e);
    for (int k = 0; k < len; k++) begin
      e.data = pay_word(seq, da, prior, k);
      e.sop  = 1'b0;
      e.eop  = (k == len - 1);
      q.push_back(e);
    end
    model_cnt++;
    @(posedge clk); #1;
    bus.vld = 1'b0;
    @(negedge clk);
    chk("hdr_latency", {30'd0, bus.wr_vld, bus.wr_sop}, 32'd3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(q.size() == 0 && bus.ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(q.size() == 0 && bus.ready), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    q.delete();
    model_cnt = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_data", bus.wr_data, held.data);
        chk("hold_flags", {29'd0, bus.wr_vld, bus.wr_sop, bus.wr_eop},
            {29'd0, 1'b1, held.sop, held.eop});
      end
      if (bus.wr_vld && bus.wr_ready) begin
        chk("word_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("word_data", bus.wr_data, e.data);
          chk("word_flags", {30'd0, bus.wr_sop, bus.wr_eop}, {30'd0, e.sop, e.eop});
        end
      end
      stall     = bus.wr_vld && !bus.wr_ready;
      held.data = bus.wr_data;
      held.sop  = bus.wr_sop;
      held.eop  = bus.wr_eop;
    end
  end

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1: bus.wr_ready = 1'($urandom_range(0, 1));
        2: begin
          bus.wr_ready = pat[pk % 4];
          pk++;
        end
        default: bus.wr_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bus.da = '0; bus.prior = '0; bus.len = '0; bus.vld = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_flags", {29'd0, bus.wr_vld, bus.wr_sop, bus.wr_eop}, 32'd0);
    chk("rst_data", bus.wr_data, 32'd0);
    chk("rst_cnt", 32'(bus.pkt_cnt), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    issue(3, 5, 4);
    drain();
    chk("cnt_after_first", 32'(bus.pkt_cnt), 32'd1);

    issue(1, 0, 0);
    gap = 0;
    @(negedge clk);
    while (!bus.ready && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    chk("ipg_cycles", 32'(gap), 32'd2);
    drain();

    bp_mode = 2;
    pk = 0;
    issue(7, 2, 3);
    drain();
    bp_mode = 0;

    bp_mode = 1;
    issue(2, 6, 8);
    repeat (3) @(posedge clk);
    #1;
    bus.da = 4'hF; bus.prior = 3'h7; bus.len = 10'd5; bus.vld = 1'b1;
    @(posedge clk); #1;
    bus.vld = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(bus.err), 32'd1);
    drain();
    chk("err_sticky", 32'(bus.err), 32'd1);
    chk("cnt_after_stray", 32'(bus.pkt_cnt), 32'(model_cnt));

    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 20)));
    end
    drain();
    chk("cnt_after_random", 32'(bus.pkt_cnt), 32'(model_cnt));

    bp_mode = 0;
    issue(9, 3, 10);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_flags", {29'd0, bus.wr_vld, bus.wr_sop, bus.wr_eop}, 32'd0);
    chk("abort_data", bus.wr_data, 32'd0);
    chk("abort_cnt", 32'(bus.pkt_cnt), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    q.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(4, 1, 2);
    drain();
    chk("cnt_after_abort", 32'(bus.pkt_cnt), 32'd1);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1);
    end
    drain();
    chk("cnt_256", 32'(bus.pkt_cnt), 32'd256);
    issue(5, 5, 0);
    drain();
    chk("cnt_257", 32'(bus.pkt_cnt), 32'd257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
